paddle_input_ctrl: RTL and testbench

//  Producer side of the 4-bit paddle command vector pad_info = {l_move, r_move, l_up, r_up}

---
 rtl/paddle_input_ctrl_pkg.sv | 29 ++
 rtl/paddle_input_ctrl_if.sv | 21 ++
 rtl/paddle_input_ctrl_btn_debounce.sv | 44 ++++
 rtl/paddle_input_ctrl.sv | 55 +++++
 tb/tb_paddle_input_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/paddle_input_ctrl_pkg.sv
// Paddle input controller: shared bit positions and command decode.
// Button and pad_info vectors are 4 bits, MSB = left side.
package paddle_pkg;

  localparam int PI_LMOVE = 3;
  localparam int PI_RMOVE = 2;
  localparam int PI_LUP   = 1;
  localparam int PI_RUP   = 0;

  localparam int BTN_LUP = 3;
  localparam int BTN_LDN = 2;
  localparam int BTN_RUP = 1;
  localparam int BTN_RDN = 0;

  typedef logic [3:0] pad_t;
  typedef logic [3:0] btn_t;

  // Up and down together cancel, so move = up ^ dn.
  function automatic pad_t pad_decode(input btn_t eff);
    pad_t p;
    p           = '0;
    p[PI_LMOVE] = eff[BTN_LUP] ^ eff[BTN_LDN];
    p[PI_LUP]   = eff[BTN_LUP] & ~eff[BTN_LDN];
    p[PI_RMOVE] = eff[BTN_RUP] ^ eff[BTN_RDN];
    p[PI_RUP]   = eff[BTN_RUP] & ~eff[BTN_RDN];
    return p;
  endfunction

endpackage

// File: rtl/paddle_input_ctrl_if.sv
// Paddle input bundle: raw buttons and frame strobe in,
// per-frame paddle command and debounced levels out.
interface paddle_input_ctrl_if;
  import paddle_pkg::*;

  btn_t btn_raw;
  logic frame_tick;
  pad_t pad_info;
  btn_t btn_level;
  logic any_press;

  modport master (
    input  btn_raw, frame_tick,
    output pad_info, btn_level, any_press
  );

  modport slave (
    output btn_raw, frame_tick,
    input  pad_info, btn_level, any_press
  );
endinterface

// File: rtl/paddle_input_ctrl_btn_debounce.sv
// One-bit 2-flop synchroniser plus hold-time debounce counter.
// rise is combinational: high on the clock the level flips 0->1.
module btn_debounce #(
  parameter int DEB_CYCLES = 400_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          done;

  assign done = (s2 != level) && (cnt == LAST);
  assign rise = done & s2;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (done) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/paddle_input_ctrl.sv
// Debounces four paddle buttons, accumulates presses over a frame
// and publishes one decoded pad_info snapshot per frame_tick.
module paddle_input_ctrl
  import paddle_pkg::*;
#(
  parameter int DEB_CYCLES = 400_000
) (
  input  logic clock,
  input  logic reset,
  paddle_input_ctrl_if.master pad
);

  btn_t level;
  btn_t rise;
  btn_t sticky;
  btn_t eff;
  pad_t pad_q;
  logic any_q;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock(clock),
      .reset(reset),
      .raw  (pad.btn_raw[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  // Taps shorter than a frame survive via sticky until the next snapshot.
  assign eff = sticky | level;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sticky <= '0;
      pad_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      any_q <= |rise;
      if (pad.frame_tick) begin
        pad_q  <= pad_decode(eff);
        sticky <= level;
      end else begin
        sticky <= eff;
      end
    end
  end

  assign pad.pad_info  = pad_q;
  assign pad.btn_level = level;
  assign pad.any_press = any_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Scoreboard bench for paddle_input_ctrl with DEB_CYCLES=4.
// Stimulus queues expected snapshots/presses; monitor checks on negedge.
module tb_paddle_input_ctrl;

  typedef struct {
    logic [3:0] lvl;
    int         cyc;
  } press_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  paddle_input_ctrl_if bus ();

  paddle_input_ctrl #(
    .DEB_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pad  (bus)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic       tick_q = 1'b0;
  logic       rst_q  = 1'b0;
  logic [3:0] last_pad = 4'h0;
  logic [3:0] pad_q[$];
  press_t     press_q[$];
  press_t     pe;
  logic [3:0] pexp;

  always @(posedge clock) begin
    cyc++;
    tick_q = bus.frame_tick & reset;
    rst_q  = ~reset;
  end

  always @(negedge clock) begin
    if (rst_q) begin
      checks++;
      if ({bus.pad_info, bus.btn_level, bus.any_press} !== 9'b0) begin
        errors++;
        $display("FAIL reset_outputs: cycle %0d got pad_info=%b btn_level=%b any_press=%b, want all 0",
                 cyc, bus.pad_info, bus.btn_level, bus.any_press);
      end
    end else begin
      if (bus.any_press !== 1'b0) begin
        checks++;
        if (press_q.size() == 0) begin
          errors++;
          $display("FAIL any_press_unexpected: cycle %0d got any_press=%b btn_level=%b, want no pulse",
                   cyc, bus.any_press, bus.btn_level);
        end else begin
          pe = press_q.pop_front();
          if (bus.btn_level !== pe.lvl || cyc != pe.cyc) begin
            errors++;
            $display("FAIL press_timing: got btn_level=%b at cycle %0d, want %b at cycle %0d",
                     bus.btn_level, cyc, pe.lvl, pe.cyc);
          end
        end
      end
      checks++;
      if (tick_q) begin
        if (pad_q.size() == 0) begin
          errors++;
          $display("FAIL snapshot_unexpected: cycle %0d got pad_info=%b with no expectation",
                   cyc, bus.pad_info);
        end else begin
          pexp = pad_q.pop_front();
          if (bus.pad_info !== pexp) begin
            errors++;
            $display("FAIL snapshot: cycle %0d got pad_info=%b, want %b", cyc, bus.pad_info, pexp);
          end
        end
      end else if (bus.pad_info !== last_pad) begin
        errors++;
        $display("FAIL pad_stable: cycle %0d got pad_info=%b, want unchanged %b",
                 cyc, bus.pad_info, last_pad);
      end
    end
    last_pad = bus.pad_info;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_press(input logic [3:0] lvl, input int at);
    press_t p;
    p.lvl = lvl;
    p.cyc = at;
    press_q.push_back(p);
  endtask

  task automatic press(input logic [3:0] raw, input logic [3:0] lvl);
    bus.btn_raw = raw;
    expect_press(lvl, cyc + 6);
  endtask

  task automatic frame(input logic [3:0] exp);
    bus.frame_tick = 1'b1;
    pad_q.push_back(exp);
    @(negedge clock);
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    bus.btn_raw    = 4'hF;
    bus.frame_tick = 1'b0;
    reset          = 1'b0;
    // reset held with all buttons down and a stray frame_tick
    wait_n(6);
    bus.frame_tick = 1'b1;
    wait_n(1);
    bus.frame_tick = 1'b0;
    wait_n(13);
    bus.btn_raw = 4'h0;
    reset       = 1'b1;
    wait_n(5);

    // clean L-up press, carried one frame after release
    press(4'b1000, 4'b1000);
    wait_n(20);
    frame(4'b1010);
    wait_n(10);
    bus.btn_raw = 4'h0;
    wait_n(20);
    frame(4'b1010);
    wait_n(20);
    frame(4'b0000);

    // bouncing R-up never qualifies
    wait_n(10);
    for (int i = 0; i < 15; i++) begin
      bus.btn_raw[1] = ~bus.btn_raw[1];
      wait_n(2);
    end
    bus.btn_raw = 4'h0;
    wait_n(20);
    frame(4'b0000);

    // short R-down tap inside a frame
    wait_n(50);
    press(4'b0001, 4'b0001);
    wait_n(10);
    bus.btn_raw = 4'h0;
    wait_n(40);
    frame(4'b0100);
    wait_n(50);
    frame(4'b0000);

    // left conflict cancels, right up still decodes
    wait_n(10);
    press(4'b1110, 4'b1110);
    wait_n(30);
    frame(4'b0101);
    wait_n(30);
    frame(4'b0101);
    bus.btn_raw = 4'h0;
    wait_n(20);
    frame(4'b0101);
    wait_n(20);
    frame(4'b0000);

    // tick one cycle before vs on the level-rise cycle
    wait_n(10);
    press(4'b0100, 4'b0100);
    wait_n(5);
    frame(4'b0000);
    frame(4'b1000);

    // one-cycle reset during a partial debounce
    wait_n(10);
    bus.btn_raw = 4'b0110;
    wait_n(3);
    reset = 1'b0;
    wait_n(1);
    reset = 1'b1;
    expect_press(4'b0110, cyc + 6);
    wait_n(20);
    frame(4'b1101);
    bus.btn_raw = 4'h0;
    wait_n(20);
    frame(4'b1101);
    wait_n(10);
    frame(4'b0000);
    wait_n(5);

    checks++;
    if (pad_q.size() != 0) begin
      errors++;
      $display("FAIL snapshot_missing: got %0d unconsumed snapshots, want 0", pad_q.size());
    end
    checks++;
    if (press_q.size() != 0) begin
      errors++;
      $display("FAIL press_missing: got %0d unseen any_press pulses, want 0", press_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
